rx_frame_buf_ctrl: RTL

Ethernet receive buffer controller for the 16 KB asymmetric dual-port frame memory: 16-bit write port A, 64-bit read port B, four 4 KB banks selected by port A address bits [12:11] and port B address bits [10:9]. It writes 16-bit stream beats into one bank per frame and commits complete frames in order. It then reads committed frames back through port B as a 64-bit stream, un-interleaving the memory's byte layout. It sits between the MAC receive stream and the DMA/host-side 64-bit reader.

---
 rtl/rx_frame_buf_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_buf_ctrl.sv
// Receive frame buffer controller: 16-bit beats into a 4-slot ring, 64-bit un-interleaved readback.
// Optional macro RXBUF_DROP_EN: accept and discard frames that arrive while the ring is full.
module rx_frame_buf_ctrl #(
  parameter int SLOT_HW = 2048,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      s_tdata,
  input  logic [1:0]       s_tkeep,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  input  logic             s_tuser,
  output logic             s_tready,
  output logic [12:0]      mem_addra,
  output logic [15:0]      mem_dina,
  output logic [1:0]       mem_wea,
  output logic             mem_ena,
  output logic [10:0]      mem_addrb,
  output logic             mem_enb,
  output logic [1:0]       mem_web,
  output logic [63:0]      mem_dinb,
  input  logic [63:0]      mem_doutb,
  output logic [63:0]      m_tdata,
  output logic [7:0]       m_tkeep,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [2:0]       frames_pending,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WRITE = 2'd1;
  localparam logic [1:0]  ST_DROP  = 2'd2;
  localparam logic [10:0] HW_LAST  = 11'(SLOT_HW - 1);

  // Port B returns halfword j split as low byte at [8j], high byte at [32+8j].
  function automatic logic [63:0] unweave(input logic [63:0] d);
    return {d[63:56], d[31:24], d[55:48], d[23:16],
            d[47:40], d[15:8],  d[39:32], d[7:0]};
  endfunction

  logic [1:0]       state_r;
  logic [10:0]      hw_idx_r;
  logic [2:0]       wp_r, rp_r;
  logic [12:0]      len_r [4];
  logic [CNT_W-1:0] drop_cnt_r;
  logic [9:0]       word_cnt_r;
  logic             inflight_r, infl_last_r;
  logic [7:0]       infl_keep_r;
  logic [1:0]       fifo_cnt_r;
  logic [63:0]      data0_r, data1_r;
  logic [7:0]       keep0_r, keep1_r;
  logic             last0_r, last1_r;

  logic [2:0]  pend_s;
  logic        slot_free_s, rdy_s, acc_s, wr_s, ovf_s, commit_s, drop_s, full_drop_s;
  logic [12:0] new_len_s, cur_len_s, len_rnd_s;
  logic [9:0]  nwords_s;
  logic [7:0]  last_keep_s;
  logic        word_last_s, pop_s, issue_s, release_s;
  logic [2:0]  occ_s;
  logic [63:0] data_in_s;

  // Write-side acceptance, commit and discard decisions.
  always_comb begin
    pend_s      = wp_r - rp_r;
    slot_free_s = ~pend_s[2];
    full_drop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
`ifdef RXBUF_DROP_EN
        rdy_s = 1'b1;
`else
        rdy_s = slot_free_s;
`endif
      end
      ST_WRITE, ST_DROP: rdy_s = 1'b1;
      default:           rdy_s = 1'b0;
    endcase
    acc_s = s_tvalid & rdy_s & ~rst;
    wr_s  = acc_s & (((state_r == ST_IDLE) & slot_free_s) | (state_r == ST_WRITE));
`ifdef RXBUF_DROP_EN
    full_drop_s = acc_s & (state_r == ST_IDLE) & ~slot_free_s;
`endif
    ovf_s     = acc_s & (state_r == ST_WRITE) & ~s_tlast & (hw_idx_r == HW_LAST);
    commit_s  = wr_s & s_tlast & ~s_tuser;
    drop_s    = full_drop_s | (wr_s & s_tlast & s_tuser) | ovf_s;
    new_len_s = {1'b0, hw_idx_r, 1'b0} + ((s_tkeep == 2'b11) ? 13'd2 : 13'd1);
  end

  // Read issue control; occupancy counts the word in flight and the one leaving this cycle.
  always_comb begin
    cur_len_s   = len_r[rp_r[1:0]];
    len_rnd_s   = cur_len_s + 13'd7;
    nwords_s    = len_rnd_s[12:3];
    last_keep_s = (cur_len_s[2:0] == 3'd0) ? 8'hFF : ((8'd1 << cur_len_s[2:0]) - 8'd1);
    word_last_s = (word_cnt_r == (nwords_s - 10'd1));
    pop_s       = (fifo_cnt_r != 2'd0) & m_tready;
    occ_s       = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s     = ~rst & (pend_s != 3'd0) & (word_cnt_r != nwords_s) & (occ_s < 3'd2);
    release_s   = pop_s & last0_r;
    data_in_s   = unweave(mem_doutb);
  end

  assign s_tready       = rdy_s & ~rst;
  assign mem_ena        = wr_s;
  assign mem_wea        = wr_s ? 2'b11 : 2'b00;
  assign mem_addra      = wr_s ? {wp_r[1:0], hw_idx_r} : 13'd0;
  assign mem_dina       = wr_s ? s_tdata : 16'd0;
  assign mem_enb        = issue_s;
  assign mem_addrb      = issue_s ? {rp_r[1:0], word_cnt_r[8:0]} : 11'd0;
  assign mem_web        = 2'b00;
  assign mem_dinb       = 64'd0;
  assign m_tdata        = data0_r;
  assign m_tkeep        = keep0_r;
  assign m_tlast        = last0_r;
  assign m_tvalid       = (fifo_cnt_r != 2'd0);
  assign frames_pending = pend_s;
  assign drop_cnt       = drop_cnt_r;

  // Write FSM, slot lengths, write pointer and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hw_idx_r   <= 11'd0;
      wp_r       <= 3'd0;
      drop_cnt_r <= {CNT_W{1'b0}};
      for (int i = 0; i < 4; i++) len_r[i] <= 13'd0;
    end else if (acc_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!s_tlast) state_r <= wr_s ? ST_WRITE : ST_DROP;
          hw_idx_r <= (wr_s & ~s_tlast) ? 11'd1 : 11'd0;
        end
        ST_WRITE: begin
          if (s_tlast || ovf_s) begin
            state_r  <= s_tlast ? ST_IDLE : ST_DROP;
            hw_idx_r <= 11'd0;
          end else begin
            hw_idx_r <= hw_idx_r + 11'd1;
          end
        end
        ST_DROP: if (s_tlast) state_r <= ST_IDLE;
        default: begin
          state_r  <= ST_IDLE;
          hw_idx_r <= 11'd0;
        end
      endcase
      if (commit_s) begin
        len_r[wp_r[1:0]] <= new_len_s;
        wp_r             <= wp_r + 3'd1;
      end
      if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) drop_cnt_r <= drop_cnt_r + CNT_W'(1);
    end
  end

  // Read pointer and word issue; the slot is released when its last word leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      rp_r        <= 3'd0;
      word_cnt_r  <= 10'd0;
      inflight_r  <= 1'b0;
      infl_keep_r <= 8'd0;
      infl_last_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        infl_keep_r <= word_last_s ? last_keep_s : 8'hFF;
        infl_last_r <= word_last_s;
      end
      if (release_s) begin
        rp_r       <= rp_r + 3'd1;
        word_cnt_r <= 10'd0;
      end else if (issue_s) begin
        word_cnt_r <= word_cnt_r + 10'd1;
      end
    end
  end

  // Two-entry output skid buffer; entry 0 always drives the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt_r <= 2'd0;
      data0_r <= 64'd0; keep0_r <= 8'd0; last0_r <= 1'b0;
      data1_r <= 64'd0; keep1_r <= 8'd0; last1_r <= 1'b0;
    end else begin
      case ({inflight_r, pop_s})
        2'b11: begin
          if (fifo_cnt_r == 2'd2) begin
            data0_r <= data1_r;   keep0_r <= keep1_r;     last0_r <= last1_r;
            data1_r <= data_in_s; keep1_r <= infl_keep_r; last1_r <= infl_last_r;
          end else begin
            data0_r <= data_in_s; keep0_r <= infl_keep_r; last0_r <= infl_last_r;
          end
        end
        2'b10: begin
          if (fifo_cnt_r == 2'd0) begin
            data0_r <= data_in_s; keep0_r <= infl_keep_r; last0_r <= infl_last_r;
          end else begin
            data1_r <= data_in_s; keep1_r <= infl_keep_r; last1_r <= infl_last_r;
          end
          fifo_cnt_r <= fifo_cnt_r + 2'd1;
        end
        2'b01: begin
          data0_r <= data1_r; keep0_r <= keep1_r; last0_r <= last1_r;
          fifo_cnt_r <= fifo_cnt_r - 2'd1;
        end
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

endmodule
